// File: rtl/uart_register_bank.sv
// UART register bank: CONFIG/THRESHOLD registers, TX and RX byte FIFOs,
// sticky EVENT register with interrupt, RX idle timeout and RTS flow control.
module uart_register_bank #(
    parameter int RX_DEPTH   = 16,
    parameter int TX_DEPTH   = 16,
    parameter int RX_TIMEOUT = 1024
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic        interrupt_o,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_done_i,
    input  logic        rx_error_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        rx_rts_o,
    output logic [31:0] cfg_o,
    input  logic        write_i,
    input  logic [2:0]  write_address_i,
    input  logic [31:0] write_data_i,
    input  logic [3:0]  write_strobe_i,
    output logic        write_error_o,
    input  logic        read_i,
    input  logic [2:0]  read_address_i,
    output logic [31:0] read_data_o,
    output logic        read_error_o
);

    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_CW = RX_AW + 1;
    localparam int TX_CW = TX_AW + 1;
    localparam int TO_W  = $clog2(RX_TIMEOUT + 1);

    localparam logic [2:0] ADDR_CONFIG    = 3'd0;
    localparam logic [2:0] ADDR_TX_DATA   = 3'd1;
    localparam logic [2:0] ADDR_RX_DATA   = 3'd2;
    localparam logic [2:0] ADDR_STATUS    = 3'd3;
    localparam logic [2:0] ADDR_THRESHOLD = 3'd4;
    localparam logic [2:0] ADDR_EVENT     = 3'd5;

    // divider 53, parity enabled (even), one stop bit, 8 data bits
    localparam logic [31:0] CONFIG_RESET = 32'h000C_8035;

    logic [31:0]      config_q, config_d;
    logic [7:0]       rxThresh_q, rxThresh_d;
    logic [7:0]       txThresh_q, txThresh_d;
    logic [4:0]       events_q, events_d;
    logic [4:0]       eventSet, eventClear;
    logic             interrupt_q;
    logic             rxCondPrev_q, txCondPrev_q;
    logic [TO_W-1:0]  timeoutCnt_q, timeoutCnt_d;
    logic             timeoutFire;

    logic [7:0]       rxMem_q [RX_DEPTH];
    logic [7:0]       txMem_q [TX_DEPTH];
    logic [RX_AW-1:0] rxWrPtr_q, rxWrPtr_d, rxRdPtr_q, rxRdPtr_d;
    logic [TX_AW-1:0] txWrPtr_q, txWrPtr_d, txRdPtr_q, txRdPtr_d;
    logic [RX_CW-1:0] rxCount_q, rxCount_d;
    logic [TX_CW-1:0] txCount_q, txCount_d;

    logic rxEnable, txEnable, flowCtrl;
    logic [4:0] irqEnable;
    logic rxEmpty, rxFull, txEmpty, txFull;
    logic wrConfig, wrTxData, wrThresh, wrEvent, wrIllegal, rdRxData;
    logic txPush, txPop, txOverflow, rxPush, rxPop, rxOverflow;
    logic rxAtThresh, txAtThresh;

    assign rxEnable  = config_q[22];
    assign txEnable  = config_q[21];
    assign flowCtrl  = config_q[20];
    assign irqEnable = config_q[27:23];

    assign rxEmpty = (rxCount_q == '0);
    assign rxFull  = (rxCount_q == RX_CW'(RX_DEPTH));
    assign txEmpty = (txCount_q == '0);
    assign txFull  = (txCount_q == TX_CW'(TX_DEPTH));

    assign wrConfig  = write_i & (write_address_i == ADDR_CONFIG);
    assign wrTxData  = write_i & (write_address_i == ADDR_TX_DATA);
    assign wrThresh  = write_i & (write_address_i == ADDR_THRESHOLD);
    assign wrEvent   = write_i & (write_address_i == ADDR_EVENT);
    assign wrIllegal = write_i & ((write_address_i == ADDR_RX_DATA) |
                                  (write_address_i == ADDR_STATUS)  |
                                  (write_address_i > ADDR_EVENT));
    assign rdRxData  = read_i & (read_address_i == ADDR_RX_DATA);

    // Fullness is judged on the registered count, before any same-cycle pop
    assign txPush     = wrTxData & write_strobe_i[0] & ~txFull;
    assign txOverflow = wrTxData & write_strobe_i[0] & txFull;
    assign txPop      = tx_valid_o & tx_ready_i;
    assign rxPush     = rx_done_i & rxEnable & ~rxFull;
    assign rxOverflow = rx_done_i & rxEnable & rxFull;
    assign rxPop      = rdRxData & ~rxEmpty;

    assign rxAtThresh = (8'(rxCount_q) >= rxThresh_q);
    assign txAtThresh = (8'(txCount_q) <= txThresh_q);

    assign tx_valid_o    = ~txEmpty & txEnable;
    assign tx_data_o     = txMem_q[txRdPtr_q];
    assign rx_rts_o      = flowCtrl & (rxCount_q < RX_CW'(RX_DEPTH - 1));
    assign cfg_o         = config_q;
    assign interrupt_o   = interrupt_q;
    assign write_error_o = wrIllegal | txOverflow;

    // Byte-strobed CONFIG and THRESHOLD updates; CONFIG[31:28] never stores ones
    always_comb begin
        config_d   = config_q;
        rxThresh_d = rxThresh_q;
        txThresh_d = txThresh_q;
        if (wrConfig) begin
            for (int b = 0; b < 4; b++) begin
                if (write_strobe_i[b]) config_d[8*b +: 8] = write_data_i[8*b +: 8];
            end
        end
        config_d[31:28] = '0;
        if (wrThresh) begin
            if (write_strobe_i[0]) rxThresh_d = write_data_i[7:0];
            if (write_strobe_i[1]) txThresh_d = write_data_i[15:8];
        end
    end

    // FIFO pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth
    always_comb begin
        rxWrPtr_d = rxPush ? rxWrPtr_q + RX_AW'(1) : rxWrPtr_q;
        rxRdPtr_d = rxPop  ? rxRdPtr_q + RX_AW'(1) : rxRdPtr_q;
        txWrPtr_d = txPush ? txWrPtr_q + TX_AW'(1) : txWrPtr_q;
        txRdPtr_d = txPop  ? txRdPtr_q + TX_AW'(1) : txRdPtr_q;
        rxCount_d = rxCount_q;
        if (rxPush && !rxPop) rxCount_d = rxCount_q + RX_CW'(1);
        else if (!rxPush && rxPop) rxCount_d = rxCount_q - RX_CW'(1);
        txCount_d = txCount_q;
        if (txPush && !txPop) txCount_d = txCount_q + TX_CW'(1);
        else if (!txPush && txPop) txCount_d = txCount_q - TX_CW'(1);
    end

    // RX idle timer: saturates at RX_TIMEOUT so the event fires only once per idle stretch
    always_comb begin
        timeoutCnt_d = timeoutCnt_q;
        timeoutFire  = 1'b0;
        if (rx_done_i || rdRxData || rxEmpty) begin
            timeoutCnt_d = '0;
        end else if (timeoutCnt_q != TO_W'(RX_TIMEOUT)) begin
            timeoutCnt_d = timeoutCnt_q + TO_W'(1);
            timeoutFire  = (timeoutCnt_d == TO_W'(RX_TIMEOUT));
        end
    end

    // Sticky events: gated by irq_enable, cleared by write-one, a new set beats a clear
    always_comb begin
        eventSet    = '0;
        eventSet[0] = rxAtThresh & ~rxCondPrev_q & irqEnable[0];
        eventSet[1] = txAtThresh & ~txCondPrev_q & irqEnable[1];
        eventSet[2] = timeoutFire & irqEnable[2];
        eventSet[3] = rxOverflow & irqEnable[3];
        eventSet[4] = rx_error_i & irqEnable[4];
        eventClear  = '0;
        if (wrEvent && write_strobe_i[0]) eventClear = write_data_i[4:0];
        events_d = (events_q & ~eventClear) | eventSet;
    end

    // Combinational read mux; rejected reads return zero
    always_comb begin
        read_data_o  = '0;
        read_error_o = 1'b0;
        if (read_i) begin
            case (read_address_i)
                ADDR_CONFIG:    read_data_o = config_q;
                ADDR_RX_DATA: begin
                    if (rxEmpty) read_error_o = 1'b1;
                    else         read_data_o  = {24'b0, rxMem_q[rxRdPtr_q]};
                end
                ADDR_STATUS:    read_data_o = {12'b0, txFull, txEmpty, rxFull, rxEmpty,
                                               8'(txCount_q), 8'(rxCount_q)};
                ADDR_THRESHOLD: read_data_o = {16'b0, txThresh_q, rxThresh_q};
                ADDR_EVENT:     read_data_o = {27'b0, events_q};
                default:        read_error_o = 1'b1;
            endcase
        end
    end

    // Control state; reset empties both FIFOs immediately by clearing pointers and counts
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            config_q     <= CONFIG_RESET;
            rxThresh_q   <= 8'd1;
            txThresh_q   <= 8'd1;
            events_q     <= '0;
            interrupt_q  <= 1'b0;
            rxCondPrev_q <= 1'b0;
            txCondPrev_q <= 1'b1;
            timeoutCnt_q <= '0;
            rxWrPtr_q    <= '0;
            rxRdPtr_q    <= '0;
            txWrPtr_q    <= '0;
            txRdPtr_q    <= '0;
            rxCount_q    <= '0;
            txCount_q    <= '0;
        end else begin
            config_q     <= config_d;
            rxThresh_q   <= rxThresh_d;
            txThresh_q   <= txThresh_d;
            events_q     <= events_d;
            interrupt_q  <= |events_q;
            rxCondPrev_q <= rxAtThresh;
            txCondPrev_q <= txAtThresh;
            timeoutCnt_q <= timeoutCnt_d;
            rxWrPtr_q    <= rxWrPtr_d;
            rxRdPtr_q    <= rxRdPtr_d;
            txWrPtr_q    <= txWrPtr_d;
            txRdPtr_q    <= txRdPtr_d;
            rxCount_q    <= rxCount_d;
            txCount_q    <= txCount_d;
        end
    end

    // FIFO storage arrays; contents are only meaningful between the pointers
    always_ff @(posedge clk_i) begin
        if (rxPush) rxMem_q[rxWrPtr_q] <= rx_data_i;
        if (txPush) txMem_q[txWrPtr_q] <= write_data_i[7:0];
    end

endmodule

// File: tb/tb_uart_register_bank.sv
// Self-checking bench for uart_register_bank: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_uart_register_bank;

    localparam int TB_RX_DEPTH   = 16;
    localparam int TB_TX_DEPTH   = 16;
    localparam int TB_RX_TIMEOUT = 8;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        interrupt_o;
    logic [7:0]  rx_data_i = '0;
    logic        rx_done_i = 1'b0;
    logic        rx_error_i = 1'b0;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b0;
    logic        rx_rts_o;
    logic [31:0] cfg_o;
    logic        write_i = 1'b0;
    logic [2:0]  write_address_i = '0;
    logic [31:0] write_data_i = '0;
    logic [3:0]  write_strobe_i = '0;
    logic        write_error_o;
    logic        read_i = 1'b0;
    logic [2:0]  read_address_i = '0;
    logic [31:0] read_data_o;
    logic        read_error_o;

    int checks = 0;
    int errors = 0;

    uart_register_bank #(
        .RX_DEPTH(TB_RX_DEPTH),
        .TX_DEPTH(TB_TX_DEPTH),
        .RX_TIMEOUT(TB_RX_TIMEOUT)
    ) dut (
        .clk_i(clk_i),
        .rst_n_i(rst_n_i),
        .interrupt_o(interrupt_o),
        .rx_data_i(rx_data_i),
        .rx_done_i(rx_done_i),
        .rx_error_i(rx_error_i),
        .tx_data_o(tx_data_o),
        .tx_valid_o(tx_valid_o),
        .tx_ready_i(tx_ready_i),
        .rx_rts_o(rx_rts_o),
        .cfg_o(cfg_o),
        .write_i(write_i),
        .write_address_i(write_address_i),
        .write_data_i(write_data_i),
        .write_strobe_i(write_strobe_i),
        .write_error_o(write_error_o),
        .read_i(read_i),
        .read_address_i(read_address_i),
        .read_data_o(read_data_o),
        .read_error_o(read_error_o)
    );

    // Free-running clock
    always #5 clk_i = ~clk_i;

    // Reference model state
    logic [7:0]  mRxQ[$];
    logic [7:0]  mTxQ[$];
    logic [31:0] mCfg;
    logic [7:0]  mRxTh, mTxTh;
    logic [4:0]  mEv;
    logic        mIrq;
    int          mTo;
    logic        mPrevRx, mPrevTx;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model update: applies the register-bank rules to the inputs seen at each clock edge
    always @(posedge clk_i or negedge rst_n_i) begin : modelStep
        int rxN, txN;
        logic condRx, condTx, fire;
        logic [4:0] newEv, clr;
        if (!rst_n_i) begin
            mRxQ.delete();
            mTxQ.delete();
            mCfg    = 32'h000C_8035;
            mRxTh   = 8'd1;
            mTxTh   = 8'd1;
            mEv     = '0;
            mIrq    = 1'b0;
            mTo     = 0;
            mPrevRx = 1'b0;
            mPrevTx = 1'b1;
        end else begin
            rxN    = mRxQ.size();
            txN    = mTxQ.size();
            condRx = (rxN >= int'(mRxTh));
            condTx = (txN <= int'(mTxTh));
            fire   = 1'b0;
            if (rx_done_i || (read_i && read_address_i == 3'd2) || rxN == 0) begin
                mTo = 0;
            end else if (mTo < TB_RX_TIMEOUT) begin
                mTo++;
                fire = (mTo == TB_RX_TIMEOUT);
            end
            newEv = '0;
            if (condRx && !mPrevRx && mCfg[23]) newEv[0] = 1'b1;
            if (condTx && !mPrevTx && mCfg[24]) newEv[1] = 1'b1;
            if (fire && mCfg[25]) newEv[2] = 1'b1;
            if (rx_done_i && mCfg[22] && rxN == TB_RX_DEPTH && mCfg[26]) newEv[3] = 1'b1;
            if (rx_error_i && mCfg[27]) newEv[4] = 1'b1;
            clr = (write_i && write_address_i == 3'd5 && write_strobe_i[0]) ? write_data_i[4:0] : 5'd0;
            mIrq    = |mEv;
            mEv     = (mEv & ~clr) | newEv;
            mPrevRx = condRx;
            mPrevTx = condTx;
            if (txN > 0 && mCfg[21] && tx_ready_i) void'(mTxQ.pop_front());
            if (write_i && write_address_i == 3'd1 && write_strobe_i[0] && txN < TB_TX_DEPTH)
                mTxQ.push_back(write_data_i[7:0]);
            if (read_i && read_address_i == 3'd2 && rxN > 0) void'(mRxQ.pop_front());
            if (rx_done_i && mCfg[22] && rxN < TB_RX_DEPTH) mRxQ.push_back(rx_data_i);
            if (write_i && write_address_i == 3'd0) begin
                for (int b = 0; b < 4; b++)
                    if (write_strobe_i[b]) mCfg[8*b +: 8] = write_data_i[8*b +: 8];
                mCfg[31:28] = '0;
            end
            if (write_i && write_address_i == 3'd4) begin
                if (write_strobe_i[0]) mRxTh = write_data_i[7:0];
                if (write_strobe_i[1]) mTxTh = write_data_i[15:8];
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk_i) begin : compare
        int rxN, txN;
        logic [31:0] expRd;
        logic expRdErr, expWrErr;
        if (rst_n_i) begin
            rxN = mRxQ.size();
            txN = mTxQ.size();
            expWrErr = write_i && ((write_address_i inside {3'd2, 3'd3, 3'd6, 3'd7}) ||
                       (write_address_i == 3'd1 && write_strobe_i[0] && txN == TB_TX_DEPTH));
            expRdErr = read_i && ((read_address_i inside {3'd1, 3'd6, 3'd7}) ||
                       (read_address_i == 3'd2 && rxN == 0));
            case (read_address_i)
                3'd0: expRd = mCfg;
                3'd2: expRd = (rxN > 0) ? {24'b0, mRxQ[0]} : 32'd0;
                3'd3: expRd = {12'b0, txN == TB_TX_DEPTH, txN == 0, rxN == TB_RX_DEPTH, rxN == 0,
                               8'(txN), 8'(rxN)};
                3'd4: expRd = {16'b0, mTxTh, mRxTh};
                3'd5: expRd = {27'b0, mEv};
                default: expRd = 32'd0;
            endcase
            checkOutput("model tx_valid_o", 32'(tx_valid_o), 32'(txN > 0 && mCfg[21]));
            if (txN > 0) checkOutput("model tx_data_o", 32'(tx_data_o), 32'(mTxQ[0]));
            checkOutput("model rx_rts_o", 32'(rx_rts_o), 32'(mCfg[20] && rxN < TB_RX_DEPTH - 1));
            checkOutput("model cfg_o", cfg_o, mCfg);
            checkOutput("model interrupt_o", 32'(interrupt_o), 32'(mIrq));
            checkOutput("model write_error_o", 32'(write_error_o), 32'(expWrErr));
            checkOutput("model read_error_o", 32'(read_error_o), 32'(expRdErr));
            if (read_i) checkOutput("model read_data_o", read_data_o, expRd);
        end
    end

    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
            write_i    = 1'b0;
            read_i     = 1'b0;
            rx_done_i  = 1'b0;
            rx_error_i = 1'b0;
        end
    endtask

    task automatic writeReg(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
        write_i = 1'b1; write_address_i = a; write_data_i = d; write_strobe_i = s;
        applyStimulus(1);
    endtask

    task automatic writeCheck(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s,
                              input logic expErr, input string name);
        write_i = 1'b1; write_address_i = a; write_data_i = d; write_strobe_i = s;
        @(negedge clk_i);
        checkOutput(name, 32'(write_error_o), 32'(expErr));
        applyStimulus(1);
    endtask

    task automatic readCheck(input logic [2:0] a, input logic [31:0] expData, input logic expErr,
                             input string name);
        read_i = 1'b1; read_address_i = a;
        @(negedge clk_i);
        checkOutput({name, " data"}, read_data_o, expData);
        checkOutput({name, " err"}, 32'(read_error_o), 32'(expErr));
        applyStimulus(1);
    endtask

    task automatic rxByte(input logic [7:0] b);
        rx_done_i = 1'b1; rx_data_i = b;
        applyStimulus(1);
    endtask

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios
    initial begin
        applyStimulus(3);
        rst_n_i = 1'b1;

        // Reset values
        checkOutput("reset interrupt_o", 32'(interrupt_o), 32'd0);
        checkOutput("reset tx_valid_o", 32'(tx_valid_o), 32'd0);
        checkOutput("reset rx_rts_o", 32'(rx_rts_o), 32'd0);
        readCheck(3'd0, 32'h000C_8035, 1'b0, "reset CONFIG");
        readCheck(3'd3, 32'h0005_0000, 1'b0, "reset STATUS");
        readCheck(3'd4, 32'h0000_0101, 1'b0, "reset THRESHOLD");
        readCheck(3'd5, 32'h0000_0000, 1'b0, "reset EVENT");

        // Rejected accesses
        readCheck(3'd1, 32'h0, 1'b1, "read TX_DATA");
        readCheck(3'd6, 32'h0, 1'b1, "read unmapped 6");
        writeCheck(3'd3, 32'hFFFF_FFFF, 4'hF, 1'b1, "write STATUS");
        writeCheck(3'd2, 32'h0000_00AB, 4'hF, 1'b1, "write RX_DATA");
        writeCheck(3'd7, 32'hFFFF_FFFF, 4'hF, 1'b1, "write unmapped 7");

        // TX fill to capacity, overflow, then drain in order
        writeReg(3'd0, 32'h002C_0000, 4'b0100);
        checkOutput("cfg tx_enable", cfg_o, 32'h002C_8035);
        for (int i = 0; i < 16; i++) writeCheck(3'd1, 32'(i), 4'b0001, 1'b0, "tx push");
        writeCheck(3'd1, 32'h0000_00AA, 4'b0001, 1'b1, "tx push when full");
        readCheck(3'd3, 32'h0009_1000, 1'b0, "status tx full");
        tx_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_i);
            checkOutput("tx drain data", 32'(tx_data_o), 32'(i));
            checkOutput("tx drain valid", 32'(tx_valid_o), 32'd1);
            applyStimulus(1);
        end
        tx_ready_i = 1'b0;
        readCheck(3'd3, 32'h0005_0000, 1'b0, "status tx drained");

        // Simultaneous TX push and pop at count 5
        for (int i = 0; i < 5; i++) writeReg(3'd1, 32'(8'h10 + i), 4'b0001);
        write_i = 1'b1; write_address_i = 3'd1; write_data_i = 32'h15; write_strobe_i = 4'b0001;
        tx_ready_i = 1'b1;
        applyStimulus(1);
        tx_ready_i = 1'b0;
        readCheck(3'd3, 32'h0001_0500, 1'b0, "status push+pop");
        tx_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            checkOutput("push+pop order", 32'(tx_data_o), 32'(8'h11 + i));
            applyStimulus(1);
        end
        tx_ready_i = 1'b0;

        // RX threshold event and interrupt
        writeReg(3'd4, 32'h0000_0104, 4'b0001);
        writeReg(3'd0, 32'h00EC_0000, 4'b0100);
        for (int i = 0; i < 4; i++) rxByte(8'(8'hA0 + i));
        checkOutput("irq before event", 32'(interrupt_o), 32'd0);
        applyStimulus(1);
        readCheck(3'd5, 32'h0000_0001, 1'b0, "event rx thresh");
        checkOutput("irq after event", 32'(interrupt_o), 32'd1);
        writeReg(3'd5, 32'h0000_0001, 4'b0001);
        readCheck(3'd5, 32'h0000_0000, 1'b0, "event cleared");
        checkOutput("irq after clear", 32'(interrupt_o), 32'd0);
        for (int i = 0; i < 4; i++) readCheck(3'd2, 32'(8'hA0 + i), 1'b0, "rx pop");
        readCheck(3'd2, 32'h0, 1'b1, "rx read empty");

        // RX timeout after exactly RX_TIMEOUT idle cycles, once
        writeReg(3'd0, 32'h0200_0000, 4'b1000);
        rxByte(8'h55);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1);
            read_i = 1'b1; read_address_i = 3'd5;
            @(negedge clk_i);
            checkOutput("timeout progress", read_data_o, (k == 8) ? 32'h4 : 32'h0);
        end
        applyStimulus(1);
        writeReg(3'd5, 32'h0000_0004, 4'b0001);
        applyStimulus(10);
        readCheck(3'd5, 32'h0000_0000, 1'b0, "timeout fires once");
        readCheck(3'd2, 32'h0000_0055, 1'b0, "rx timeout byte");

        // RX overflow, then RTS flow control across the DEPTH-1 boundary
        writeReg(3'd0, 32'h0600_0000, 4'b1000);
        for (int i = 0; i < 16; i++) rxByte(8'(8'hB0 + i));
        rxByte(8'hEE);
        readCheck(3'd3, 32'h0006_0010, 1'b0, "status rx full");
        readCheck(3'd5, 32'h0000_0009, 1'b0, "event overflow");
        writeReg(3'd0, 32'h00FC_0000, 4'b0100);
        checkOutput("rts at 16", 32'(rx_rts_o), 32'd0);
        readCheck(3'd2, 32'h0000_00B0, 1'b0, "rx pop first");
        checkOutput("rts at 15", 32'(rx_rts_o), 32'd0);
        readCheck(3'd2, 32'h0000_00B1, 1'b0, "rx pop second");
        checkOutput("rts at 14", 32'(rx_rts_o), 32'd1);
        for (int i = 2; i < 16; i++) readCheck(3'd2, 32'(8'hB0 + i), 1'b0, "rx drain");
        readCheck(3'd2, 32'h0, 1'b1, "rx empty after drain");

        // Same-cycle set beats clear
        writeReg(3'd5, 32'h0000_001F, 4'b0001);
        writeReg(3'd0, 32'h0E00_0000, 4'b1000);
        write_i = 1'b1; write_address_i = 3'd5; write_data_i = 32'h10; write_strobe_i = 4'b0001;
        rx_error_i = 1'b1;
        applyStimulus(1);
        readCheck(3'd5, 32'h0000_0010, 1'b0, "set wins over clear");

        // Byte strobes and TX threshold event
        writeReg(3'd4, 32'hFFFF_0302, 4'b0010);
        readCheck(3'd4, 32'h0000_0304, 1'b0, "threshold strobe");
        writeReg(3'd0, 32'hFFFF_FFFF, 4'b1000);
        readCheck(3'd0, 32'h0FFC_8035, 1'b0, "config strobe mask");
        for (int i = 0; i < 5; i++) writeReg(3'd1, 32'(8'h60 + i), 4'b0001);
        tx_ready_i = 1'b1;
        applyStimulus(6);
        tx_ready_i = 1'b0;
        readCheck(3'd5, 32'h0000_0012, 1'b0, "event tx thresh");

        // Reset in the middle of traffic empties everything at once
        for (int i = 0; i < 3; i++) writeReg(3'd1, 32'(8'h70 + i), 4'b0001);
        rxByte(8'h80);
        rxByte(8'h81);
        rst_n_i = 1'b0;
        #1;
        checkOutput("mid reset tx_valid_o", 32'(tx_valid_o), 32'd0);
        checkOutput("mid reset rx_rts_o", 32'(rx_rts_o), 32'd0);
        checkOutput("mid reset interrupt_o", 32'(interrupt_o), 32'd0);
        checkOutput("mid reset cfg_o", cfg_o, 32'h000C_8035);
        applyStimulus(2);
        rst_n_i = 1'b1;
        readCheck(3'd3, 32'h0005_0000, 1'b0, "status after reset");
        readCheck(3'd2, 32'h0, 1'b1, "rx empty after reset");

        applyStimulus(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
